// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII frame receiver.
// Holds the parser state encoding and the CRC-32 helpers used by the optional check.
package rgmii_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    END
  } rx_state_e;

  localparam int unsigned PREAMBLE_LEN = 8;
  localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // LSB-first update, so the register holds the reflected CRC.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ bitrev32(CRC_POLY)) : (c >> 1);
    return c;
  endfunction

  function automatic logic crc_residue_ok(input logic [31:0] crc);
    return bitrev32(crc) == CRC_RESIDUE;
  endfunction

endpackage

// File: rtl/rgmii_ddr_cap.sv
// RGMII DDR capture: low nibble on the rising edge, high nibble on the falling edge,
// presented as one registered byte per rxclk cycle.
module rgmii_ddr_cap
  import rgmii_pkg::*;
(
  input  logic       rxclk,
  input  logic       rst,
  input  logic       rxctl,
  input  logic [3:0] rxd,
  output logic [7:0] rxbyte,
  output logic       byte_en
);

  logic [3:0] lo_q;
  logic [3:0] hi_q;
  logic       ctl_q;
  logic       blk_q;

  always_ff @(negedge rxclk) hi_q <= rxd;

  // blk_q masks the tail of a frame cut by reset until rxctl has been seen low.
  always_ff @(posedge rxclk) begin
    if (rst) begin
      lo_q    <= '0;
      ctl_q   <= 1'b0;
      blk_q   <= 1'b1;
      rxbyte  <= '0;
      byte_en <= 1'b0;
    end else begin
      lo_q    <= rxd;
      ctl_q   <= rxctl & ~blk_q;
      blk_q   <= blk_q & rxctl;
      rxbyte  <= {hi_q, lo_q};
      byte_en <= ctl_q;
    end
  end

endmodule

// File: rtl/rgmii_frame_rx.sv
// RGMII frame receiver: header field extraction and addressed payload streaming.
// Define RGMII_RX_CRC_EN to check the FCS and strip it from the payload stream.
module rgmii_frame_rx
  import rgmii_pkg::*;
#(
  parameter int unsigned HDR_OFS     = 22,
  parameter int unsigned FIELD_BYTES = 2,
  parameter int unsigned PAYLOAD_MAX = 1500,
  parameter int unsigned ADDR_W      = 14
) (
  input  logic              rxclk,
  input  logic              rst,
  input  logic              rxctl,
  input  logic [3:0]        rxd,
  output logic [7:0]        dout,
  output logic              dvalid,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] cycle,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              overlong
);

  localparam int unsigned FW        = 8 * FIELD_BYTES;
  localparam logic [15:0] HDR_FIRST = 16'(HDR_OFS);
  localparam logic [15:0] HDR_LAST  = 16'(HDR_OFS + 2 * FIELD_BYTES - 1);
  localparam logic [15:0] PAY_FIRST = 16'(HDR_OFS + 2 * FIELD_BYTES);
  localparam logic [15:0] PMAX      = 16'(PAYLOAD_MAX);

  logic [7:0]    rxbyte;
  logic          byte_en;
  rx_state_e     state_q, state_d;
  logic [15:0]   cnt_q, idx, pidx;
  logic          start, in_hdr, hdr_last, is_pay;
  logic          done_d, ok_d, crc_good;
  logic [FW-1:0] sb_q, sl_q, sb_d, sl_d;
  logic          pay_en, pay_fwd;
  logic [7:0]    pay_byte;
  logic [15:0]   pay_idx;

  rgmii_ddr_cap u_cap (
    .rxclk   (rxclk),
    .rst     (rst),
    .rxctl   (rxctl),
    .rxd     (rxd),
    .rxbyte  (rxbyte),
    .byte_en (byte_en)
  );

  // A byte arriving in IDLE or END is byte 0 of a new frame.
  assign start    = byte_en && (state_q == IDLE || state_q == END);
  assign idx      = start ? '0 : cnt_q;
  assign in_hdr   = byte_en && (idx >= HDR_FIRST) && (idx <= HDR_LAST);
  assign hdr_last = byte_en && (idx == HDR_LAST);
  assign is_pay   = byte_en && (idx >= PAY_FIRST);
  assign pidx     = idx - PAY_FIRST;

  always_ff @(posedge rxclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    unique case (state_q)
      IDLE, END: begin
        if (byte_en) state_d = hdr_last ? PAYLOAD : HDR;
        else         state_d = IDLE;
      end
      HDR: begin
        if (!byte_en) begin
          state_d = END;
          done_d  = 1'b1;
        end else if (hdr_last) begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!byte_en) begin
          state_d = END;
          done_d  = 1'b1;
          ok_d    = crc_good;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sb_d = sb_q;
    sl_d = sl_q;
    for (int unsigned i = 0; i < FIELD_BYTES; i++) begin
      if (in_hdr && idx == 16'(HDR_OFS + i))               sb_d[8*i +: 8] = rxbyte;
      if (in_hdr && idx == 16'(HDR_OFS + FIELD_BYTES + i)) sl_d[8*i +: 8] = rxbyte;
    end
  end

`ifdef RGMII_RX_CRC_EN
  logic [3:0][7:0]  pd_q;
  logic [3:0][15:0] pp_q;
  logic [3:0]       pv_q;
  logic [31:0]      crc_q;

  // Four-byte hold-back: a byte leaves only once four more have arrived, so the FCS never does.
  always_ff @(posedge rxclk) begin
    if (rst) begin
      pd_q  <= '0;
      pp_q  <= '0;
      pv_q  <= '0;
      crc_q <= '1;
    end else if (start) begin
      pv_q  <= '0;
      crc_q <= '1;
    end else begin
      if (is_pay) begin
        pd_q <= {pd_q[2:0], rxbyte};
        pp_q <= {pp_q[2:0], pidx};
        pv_q <= {pv_q[2:0], 1'b1};
      end
      if (byte_en && idx >= 16'(PREAMBLE_LEN)) crc_q <= crc32_byte(crc_q, rxbyte);
    end
  end

  assign pay_en   = is_pay && pv_q[3];
  assign pay_byte = pd_q[3];
  assign pay_idx  = pp_q[3];
  assign crc_good = crc_residue_ok(crc_q);
`else
  assign pay_en   = is_pay;
  assign pay_byte = rxbyte;
  assign pay_idx  = pidx;
  assign crc_good = 1'b1;
`endif

  assign pay_fwd = pay_en && (pay_idx < PMAX);

  always_ff @(posedge rxclk) begin
    if (rst) begin
      cnt_q      <= '0;
      sb_q       <= '0;
      sl_q       <= '0;
      dout       <= '0;
      dvalid     <= 1'b0;
      addr       <= '0;
      base       <= '0;
      cycle      <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      overlong   <= 1'b0;
    end else begin
      if (byte_en) cnt_q <= (idx == 16'hFFFF) ? idx : idx + 16'd1;
      sb_q <= sb_d;
      sl_q <= sl_d;
      if (hdr_last) begin
        base  <= ADDR_W'(sb_d);
        cycle <= ADDR_W'(sl_d);
      end
      dvalid <= pay_fwd;
      if (pay_fwd) begin
        dout <= pay_byte;
        addr <= base + ADDR_W'(pay_idx);
      end
      overlong   <= start ? 1'b0 : (overlong | (pay_en && pay_idx >= PMAX));
      frame_done <= done_d;
      frame_ok   <= ok_d;
    end
  end

endmodule

// File: tb/tb_rgmii_frame_rx.sv
// Randomised frame bench for rgmii_frame_rx with a frame-level reference model.
// Build with RGMII_RX_CRC_EN defined to also cover FCS checking and stripping.
`timescale 1ns/1ps
module tb_rgmii_frame_rx;

  localparam int unsigned HDR_OFS     = 22;
  localparam int unsigned FIELD_BYTES = 2;
  localparam int unsigned PAYLOAD_MAX = 1500;
  localparam int unsigned ADDR_W      = 14;
  localparam int unsigned P0          = HDR_OFS + 2 * FIELD_BYTES;
`ifdef RGMII_RX_CRC_EN
  localparam int unsigned FCSN = 4;
  localparam int unsigned LAT  = 6;
`else
  localparam int unsigned FCSN = 0;
  localparam int unsigned LAT  = 2;
`endif

  logic              rxclk = 1'b0;
  logic              rst, rxctl;
  logic [3:0]        rxd;
  logic [7:0]        dout;
  logic              dvalid, frame_done, frame_ok, overlong;
  logic [ADDR_W-1:0] addr, base, cycle;

  rgmii_frame_rx #(
    .HDR_OFS     (HDR_OFS),
    .FIELD_BYTES (FIELD_BYTES),
    .PAYLOAD_MAX (PAYLOAD_MAX),
    .ADDR_W      (ADDR_W)
  ) dut (
    .rxclk      (rxclk),
    .rst        (rst),
    .rxctl      (rxctl),
    .rxd        (rxd),
    .dout       (dout),
    .dvalid     (dvalid),
    .addr       (addr),
    .base       (base),
    .cycle      (cycle),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .overlong   (overlong)
  );

  always #5 rxclk = ~rxclk;

  int unsigned cyc = 0;
  always @(posedge rxclk) cyc <= cyc + 1;

  typedef struct {
    int unsigned       at;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } beat_t;

  typedef struct {
    int unsigned       at;
    logic              ok;
    logic              ovl;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
  } frame_t;

  beat_t             expq[$];
  frame_t            frq[$];
  logic [7:0]        frm[$];
  bit                frm_bad;
  logic [ADDR_W-1:0] m_base = '0, m_len = '0;
  int unsigned       rst_edge = 32'hFFFF_FFFF;
  int unsigned       errors = 0, checks = 0;
  beat_t             mb;
  frame_t            mf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input logic [15:0] bs, input logic [15:0] ln, input int unsigned npay,
                       input bit corrupt);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 7; i++) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 0; i < 14; i++) frm.push_back(8'($urandom));
    frm.push_back(bs[7:0]);
    frm.push_back(bs[15:8]);
    frm.push_back(ln[7:0]);
    frm.push_back(ln[15:8]);
    for (int unsigned i = 0; i < npay; i++) frm.push_back(8'($urandom));
    if (FCSN != 0) begin
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < frm.size(); i++) c = crc_upd(c, frm[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
      if (corrupt) frm[P0] = frm[P0] ^ (8'h01 << $urandom_range(0, 7));
    end
    frm_bad = corrupt;
  endtask

  task automatic drive(input logic ctl, input logic [7:0] b, input logic r, output int unsigned at);
    @(negedge rxclk);
    #2;
    rxctl = ctl;
    rxd   = b[3:0];
    rst   = r;
    @(posedge rxclk);
    #2;
    at  = cyc;
    rxd = b[7:4];
    rst = 1'b0;
  endtask

  task automatic purge(input int unsigned r);
    for (int i = int'(expq.size()) - 1; i >= 0; i--) if (expq[i].at >= r) expq.delete(i);
    for (int i = int'(frq.size()) - 1; i >= 0; i--) if (frq[i].at >= r) frq.delete(i);
  endtask

  // Sends frm, queues the expected beats and end-of-frame record, then idles for gap cycles.
  task automatic send(input int rst_at, input int unsigned gap);
    int unsigned       at, n;
    bit                aborted;
    beat_t             b;
    frame_t            f;
    logic [15:0]       hb, hl;
    aborted = 0;
    n  = frm.size();
    hb = {frm[HDR_OFS+1], frm[HDR_OFS]};
    hl = (n >= P0) ? {frm[HDR_OFS+3], frm[HDR_OFS+2]} : 16'h0;
    for (int unsigned i = 0; i < n; i++) begin
      drive(1'b1, frm[i], int'(i) == rst_at, at);
      if (int'(i) == rst_at) begin
        aborted  = 1;
        rst_edge = at;
        purge(at);
        m_base = '0;
        m_len  = '0;
      end else if (!aborted && i >= P0 && i < n - FCSN && (i - P0) < PAYLOAD_MAX) begin
        b.at   = at + LAT;
        b.addr = ADDR_W'(int'(hb) + int'(i - P0));
        b.data = frm[i];
        expq.push_back(b);
      end
    end
    drive(1'b0, 8'h00, 1'b0, at);
    if (!aborted) begin
      if (n >= P0) begin
        m_base = hb[ADDR_W-1:0];
        m_len  = hl[ADDR_W-1:0];
      end
      f.at   = at + 2;
      f.ok   = (n >= P0) && !(FCSN != 0 && frm_bad);
      f.ovl  = (n - FCSN) > (P0 + PAYLOAD_MAX);
      f.base = m_base;
      f.len  = m_len;
      frq.push_back(f);
    end
    for (int unsigned g = 1; g < gap; g++) drive(1'b0, 8'h00, 1'b0, at);
  endtask

  always @(negedge rxclk) begin
    if (cyc == rst_edge) begin
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_dvalid", 32'(dvalid), 32'h0);
      check("rst_addr", 32'(addr), 32'h0);
      check("rst_base", 32'(base), 32'h0);
      check("rst_cycle", 32'(cycle), 32'h0);
      check("rst_done", 32'(frame_done), 32'h0);
      check("rst_ok", 32'(frame_ok), 32'h0);
      check("rst_overlong", 32'(overlong), 32'h0);
    end
    if (dvalid === 1'b1) begin
      if (expq.size() == 0) check("dvalid_extra", 32'(dvalid), 32'h0);
      else begin
        mb = expq.pop_front();
        check("dvalid_cycle", cyc, mb.at);
        check("addr", 32'(addr), 32'(mb.addr));
        check("dout", 32'(dout), 32'(mb.data));
      end
    end else if (expq.size() != 0 && expq[0].at <= cyc) begin
      check("dvalid_missing", 32'(dvalid), 32'h1);
      void'(expq.pop_front());
    end
    if (frame_done === 1'b1) begin
      if (frq.size() == 0) check("done_extra", 32'(frame_done), 32'h0);
      else begin
        mf = frq.pop_front();
        check("done_cycle", cyc, mf.at);
        check("frame_ok", 32'(frame_ok), 32'(mf.ok));
        check("overlong", 32'(overlong), 32'(mf.ovl));
        check("base", 32'(base), 32'(mf.base));
        check("cycle", 32'(cycle), 32'(mf.len));
      end
    end else if (frq.size() != 0 && frq[0].at <= cyc) begin
      check("done_missing", 32'(frame_done), 32'h1);
      void'(frq.pop_front());
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: no finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned at;
    rst   = 1'b1;
    rxctl = 1'b0;
    rxd   = 4'h0;
    repeat (3) @(posedge rxclk);
    @(negedge rxclk);
    check("init_dout", 32'(dout), 32'h0);
    check("init_dvalid", 32'(dvalid), 32'h0);
    check("init_addr", 32'(addr), 32'h0);
    check("init_base", 32'(base), 32'h0);
    check("init_cycle", 32'(cycle), 32'h0);
    check("init_done", 32'(frame_done), 32'h0);
    check("init_ok", 32'(frame_ok), 32'h0);
    check("init_overlong", 32'(overlong), 32'h0);
    rst = 1'b0;
    repeat (3) drive(1'b0, 8'h00, 1'b0, at);

    build(16'h1234, 16'h0010, 16, 0);
    send(-1, 5);
    build(16'h3FFE, 16'h0004, 4, 0);
    send(-1, 5);
    build(16'h5555, 16'h0007, 10, 0);
    while (frm.size() > 23) void'(frm.pop_back());
    send(-1, 5);
    build(16'h0100, 16'(PAYLOAD_MAX + 3), PAYLOAD_MAX + 3, 0);
    send(-1, 5);
    if (FCSN != 0) begin
      build(16'h0200, 16'h0008, 8, 0);
      send(-1, 3);
      build(16'h0300, 16'h0008, 8, 1);
      send(-1, 3);
    end

    for (int k = 0; k < 20; k++) begin
      build(16'($urandom), 16'($urandom), $urandom_range(0, 40),
            (FCSN != 0) && ($urandom_range(0, 3) == 0));
      send(-1, $urandom_range(1, 4));
    end

    build(16'h0A00, 16'h0014, 20, 0);
    send(-1, 1);
    build(16'h0B00, 16'h001E, 30, 0);
    send(int'(P0) + 10, 1);
    build(16'h0C00, 16'h000C, 12, 0);
    send(-1, 5);

    repeat (20) drive(1'b0, 8'h00, 1'b0, at);
    check("beats_pending", expq.size(), 32'h0);
    check("frames_pending", frq.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
